plab3_mem_line_mem_responder: RTL and testbench

- Cacheline-granularity test memory; the responder end of the memreq/memresp interface driven by the blocking caches.
- Accepts one 128-bit line request at a time over val/rdy, holds it for a programmable latency, then returns a memresp message.
- Backed by an internal line array; serves as the cache's main-memory model in unit and integration benches.

---
 rtl/plab3_mem_line_pkg.sv | 23 ++
 rtl/plab3_mem_line_mem_responder_ctrl.sv | 72 +++++++
 rtl/plab3_mem_line_mem_responder.sv | 100 ++++++++++
 tb/tb_plab3_mem_line_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/plab3_mem_line_pkg.sv
// Shared definitions for the line-granularity test memory responder:
// memory message type codes, line geometry and the responder FSM encoding.
package plab3_mem_line_pkg;

    localparam int CLW            = 128;
    localparam int LINE_OFF_NBITS = 4;

    localparam logic [2:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] MEM_TYPE_WRITE_INIT = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only full-line writes touch the array; every other type is a read.
    function automatic logic is_write(input logic [2:0] mem_type);
        return (mem_type == MEM_TYPE_WRITE) || (mem_type == MEM_TYPE_WRITE_INIT);
    endfunction

endpackage

// File: rtl/plab3_mem_line_mem_responder_ctrl.sv
// Responder control: request/response handshake FSM plus latency down-counter.
//
//   state | meaning
//   IDLE  | ready for a request; accept fires on memreq_val
//   WAIT  | request held; counter runs p_latency down to 1
//   RESP  | response valid and stable until memresp_rdy
module plab3_mem_line_mem_responder_ctrl
    import plab3_mem_line_pkg::*;
#(
    parameter int p_latency = 2
)(
    input  logic clk,
    input  logic reset,
    input  logic memreq_val,
    output logic memreq_rdy,
    output logic memresp_val,
    input  logic memresp_rdy,
    output logic req_go
);

    localparam logic [7:0] LAT = p_latency[7:0];

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic [7:0] count_next;

    // Handshake outputs are forced low while reset is held.
    always_comb begin
        memreq_rdy  = !reset && (state == IDLE);
        memresp_val = !reset && (state == RESP);
        req_go      = memreq_val && memreq_rdy;
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (req_go) begin
                    if (LAT != 8'd0) begin
                        state_next = WAIT;
                        count_next = LAT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (count == 8'd1) state_next = RESP;
                else               count_next = count - 8'd1;
            end
            RESP: begin
                if (memresp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/plab3_mem_line_mem_responder.sv
// Cacheline-granularity test memory: accepts one 128-bit line request at a
// time, holds it for p_latency cycles and returns a memresp message.
// Optional request statistics: PLAB3_MEM_LINE_RESP_STATS_EN.
module plab3_mem_line_mem_responder
    import plab3_mem_line_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_mem_nlines   = 256,
    parameter int p_latency      = 2
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [3+p_opaque_nbits+32+4+CLW-1:0]  memreq_msg,
    input  logic                                  memreq_val,
    output logic                                  memreq_rdy,
    output logic [3+p_opaque_nbits+4+CLW-1:0]     memresp_msg,
    output logic                                  memresp_val,
    input  logic                                  memresp_rdy
`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
    ,
    output logic [31:0]                           num_reads,
    output logic [31:0]                           num_writes
`endif
);

    localparam int ABW       = 32;
    localparam int O         = p_opaque_nbits;
    localparam int IDX_NBITS = $clog2(p_mem_nlines);

    logic [2:0]           req_type;
    logic [O-1:0]         req_opaque;
    logic [ABW-1:0]       req_addr;
    logic [3:0]           req_len;
    logic [CLW-1:0]       req_data;
    logic [IDX_NBITS-1:0] req_idx;
    logic                 req_go;

    logic [2:0]           type_reg;
    logic [O-1:0]         opaque_reg;
    logic [CLW-1:0]       data_reg;

    logic [CLW-1:0]       mem [p_mem_nlines];

    // Request fields; the byte offset and bits above the index are dropped,
    // so addresses alias modulo the array size.
    assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;
    assign req_idx = req_addr[LINE_OFF_NBITS +: IDX_NBITS];

    logic unused_bits;
    assign unused_bits = &{1'b0, req_len, req_addr};

    plab3_mem_line_mem_responder_ctrl #(.p_latency(p_latency)) ctrl (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .req_go      (req_go)
    );

    // Full-line write at the accept edge; the array is never cleared.
    always_ff @(posedge clk) begin
        if (req_go && is_write(req_type)) mem[req_idx] <= req_data;
    end

    // Response registers. Only one request is in flight and nothing else
    // writes the array, so sampling the line at accept gives the same value
    // as sampling it on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            type_reg   <= 3'd0;
            opaque_reg <= '0;
            data_reg   <= '0;
        end else if (req_go) begin
            type_reg   <= req_type;
            opaque_reg <= req_opaque;
            data_reg   <= is_write(req_type) ? '0 : mem[req_idx];
        end
    end

    assign memresp_msg = {type_reg, opaque_reg, 4'd0, data_reg};

`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
    // Saturating request counters; non-write types count as reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reads  <= 32'd0;
            num_writes <= 32'd0;
        end else if (req_go) begin
            if (is_write(req_type)) begin
                if (num_writes != 32'hFFFF_FFFF) num_writes <= num_writes + 32'd1;
            end else begin
                if (num_reads != 32'hFFFF_FFFF) num_reads <= num_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Directed bench for the line memory responder: one instance at latency 2,
// one at latency 0.
module tb_plab3_mem_line_mem_responder;
    import plab3_mem_line_pkg::*;

    localparam logic [2:0] T_AMO_ADD = 3'd3;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF00000000CAFEF00D11112222;
    localparam logic [127:0] D3 = 128'h55555555AAAAAAAA5555AAAA0F0F0F0F;
    localparam logic [127:0] D4 = 128'h00000000000000000000000000000777;

    logic         clk = 1'b0;
    logic         reset;
    logic [174:0] req_msg;
    logic         req_val;
    logic         req_rdy;
    logic [142:0] resp_msg;
    logic         resp_val;
    logic         resp_rdy;

    logic [174:0] req_msg_z;
    logic         req_val_z;
    logic         req_rdy_z;
    logic [142:0] resp_msg_z;
    logic         resp_val_z;
    logic         resp_rdy_z;

`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
    logic [31:0]  num_reads, num_writes, num_reads_z, num_writes_z;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    plab3_mem_line_mem_responder #(.p_latency(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (req_msg),
        .memreq_val  (req_val),
        .memreq_rdy  (req_rdy),
        .memresp_msg (resp_msg),
        .memresp_val (resp_val),
        .memresp_rdy (resp_rdy)
`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
        ,
        .num_reads   (num_reads),
        .num_writes  (num_writes)
`endif
    );

    plab3_mem_line_mem_responder #(.p_latency(0)) dut_z (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (req_msg_z),
        .memreq_val  (req_val_z),
        .memreq_rdy  (req_rdy_z),
        .memresp_msg (resp_msg_z),
        .memresp_val (resp_val_z),
        .memresp_rdy (resp_rdy_z)
`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
        ,
        .num_reads   (num_reads_z),
        .num_writes  (num_writes_z)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [174:0] pack_req(input logic [2:0] t, input logic [7:0] op,
                                              input logic [31:0] addr, input logic [127:0] data);
        return {t, op, addr, 4'd0, data};
    endfunction

    // Full transaction on the latency-2 instance, measuring cycles from fire
    // to response valid (fire cycle t, valid in cycle t+1+latency).
    task automatic txn(input string tag, input logic [2:0] t, input logic [31:0] addr,
                       input logic [127:0] data, input logic [7:0] op, input logic [127:0] exp_data);
        int n;
        @(negedge clk);
        req_msg = pack_req(t, op, addr, data);
        req_val = 1'b1;
        check_eq({tag, "/req_rdy"}, 128'(req_rdy), 128'd1);
        @(negedge clk);
        req_val = 1'b0;
        n = 1;
        while (!resp_val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "/lat"}, 128'(n), 128'd3);
        check_eq({tag, "/type"}, 128'(resp_msg[142:140]), 128'(t));
        check_eq({tag, "/opaque"}, 128'(resp_msg[139:132]), 128'(op));
        check_eq({tag, "/len"}, 128'(resp_msg[131:128]), 128'd0);
        check_eq({tag, "/data"}, resp_msg[127:0], exp_data);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check_eq({tag, "/val_done"}, 128'(resp_val), 128'd0);
    endtask

    initial begin
        logic [142:0] held;
        int fires;
        int n;

        reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0; req_msg = '0;
        req_val_z = 1'b0; resp_rdy_z = 1'b0; req_msg_z = '0;
        repeat (2) @(negedge clk);
        check_eq("rst/req_rdy", 128'(req_rdy), 128'd0);
        check_eq("rst/resp_val", 128'(resp_val), 128'd0);
        check_eq("rst/req_rdy_z", 128'(req_rdy_z), 128'd0);
        reset = 1'b0;
        #1;
        check_eq("rst/msg", 128'(resp_msg), 128'd0);
        check_eq("rst/idle_rdy", 128'(req_rdy), 128'd1);

        // Write/read round trips, aliasing, WRITE_INIT and an AMO.
        txn("wr40", MEM_TYPE_WRITE, 32'h0000_0040, D1, 8'h05, 128'd0);
        txn("rd40", MEM_TYPE_READ, 32'h0000_0040, 128'd0, 8'h06, D1);
        txn("wr1004", MEM_TYPE_WRITE, 32'h0000_1004, D2, 8'h07, 128'd0);
        txn("rd0", MEM_TYPE_READ, 32'h0000_0000, 128'd0, 8'h08, D2);
        txn("rd40b", MEM_TYPE_READ, 32'h0000_004C, 128'd0, 8'h09, D1);
        txn("wi50", MEM_TYPE_WRITE_INIT, 32'h0000_0050, D3, 8'hA0, 128'd0);
        txn("rd50", MEM_TYPE_READ, 32'h0000_0050, 128'd0, 8'hA1, D3);
        txn("amo40", T_AMO_ADD, 32'h0000_0040, D4, 8'hA2, D1);
        txn("rd40c", MEM_TYPE_READ, 32'h0000_0040, 128'd0, 8'hA3, D1);

        // Backpressure: response held, new write offered but not accepted.
        @(negedge clk);
        req_msg = pack_req(MEM_TYPE_READ, 8'h33, 32'h0000_0050, 128'd0);
        req_val = 1'b1;
        @(negedge clk);
        req_msg = pack_req(MEM_TYPE_WRITE, 8'h44, 32'h0000_0050, D4);
        n = 1;
        while (!resp_val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp/lat", 128'(n), 128'd3);
        held = resp_msg;
        check_eq("bp/data", held[127:0], D3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp/val", 128'(resp_val), 128'd1);
            check_eq("bp/msg", 128'(resp_msg ^ held), 128'd0);
            check_eq("bp/req_rdy", 128'(req_rdy), 128'd0);
        end
        req_val = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        txn("bp/rd50", MEM_TYPE_READ, 32'h0000_0050, 128'd0, 8'h45, D3);

        // Reset while waiting drops the request.
        @(negedge clk);
        req_msg = pack_req(MEM_TYPE_READ, 8'h66, 32'h0000_0040, 128'd0);
        req_val = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid/rst_rdy", 128'(req_rdy), 128'd0);
        reset = 1'b0;
        #1;
        check_eq("mid/idle_rdy", 128'(req_rdy), 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("mid/no_resp", 128'(resp_val), 128'd0);
        end
        txn("mid/rd1000", MEM_TYPE_READ, 32'h0000_1000, 128'd0, 8'h67, D2);

`ifdef PLAB3_MEM_LINE_RESP_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("st/reads0", 128'(num_reads), 128'd0);
        check_eq("st/writes0", 128'(num_writes), 128'd0);
        txn("st/w60", MEM_TYPE_WRITE, 32'h0000_0060, D1, 8'h01, 128'd0);
        txn("st/w70", MEM_TYPE_WRITE, 32'h0000_0070, D2, 8'h02, 128'd0);
        txn("st/w80", MEM_TYPE_WRITE_INIT, 32'h0000_0080, D3, 8'h03, 128'd0);
        txn("st/amo60", T_AMO_ADD, 32'h0000_0060, D4, 8'h04, D1);
        txn("st/r60", MEM_TYPE_READ, 32'h0000_0060, 128'd0, 8'h05, D1);
        txn("st/r70", MEM_TYPE_READ, 32'h0000_0070, 128'd0, 8'h06, D2);
        check_eq("st/reads", 128'(num_reads), 128'd3);
        check_eq("st/writes", 128'(num_writes), 128'd3);
`endif

        // Zero-latency instance: response in the cycle after fire.
        @(negedge clk);
        req_msg_z = pack_req(MEM_TYPE_WRITE, 8'h11, 32'h0000_0020, D4);
        req_val_z = 1'b1;
        check_eq("z/wr_rdy", 128'(req_rdy_z), 128'd1);
        @(negedge clk);
        req_val_z = 1'b0;
        check_eq("z/wr_val", 128'(resp_val_z), 128'd1);
        check_eq("z/wr_type", 128'(resp_msg_z[142:140]), 128'(MEM_TYPE_WRITE));
        check_eq("z/wr_data", resp_msg_z[127:0], 128'd0);
        resp_rdy_z = 1'b1;
        @(negedge clk);
        resp_rdy_z = 1'b0;

        // Back-to-back reads with the consumer always ready: one accept every
        // two cycles.
        @(negedge clk);
        req_msg_z = pack_req(MEM_TYPE_READ, 8'h12, 32'h0000_0020, 128'd0);
        req_val_z = 1'b1;
        resp_rdy_z = 1'b1;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            check_eq("z/b2b_rdy", 128'(req_rdy_z), 128'((i % 2) == 0));
            check_eq("z/b2b_val", 128'(resp_val_z), 128'((i % 2) == 1));
            if (resp_val_z) check_eq("z/b2b_data", resp_msg_z[127:0], D4);
            if (req_rdy_z) fires++;
            @(negedge clk);
        end
        req_val_z = 1'b0;
        resp_rdy_z = 1'b0;
        check_eq("z/b2b_fires", 128'(fires), 128'd4);
        check_eq("z/idle_end", 128'(req_rdy_z), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
